// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand width, display digit
// count and the converter state encoding.
package calc_pkg;

  localparam int CALC_WIDTH  = 28;
  localparam int CALC_DIGITS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? (din + 4'd3) : din;
  end

endmodule

// File: rtl/bin2bcd_conv.sv
// Signed binary to sign + packed BCD converter (shift-and-add-3), one bit per
// cycle. Results are registered on entry to DONE, so valid_out is high while DONE.
module bin2bcd_conv
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [WIDTH-1:0]      d_in,
  input  logic                  err_in,
  output logic                  busy,
  output logic                  valid_out,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  err_out
);

  localparam int CW = $clog2(WIDTH);
  localparam int BW = 4 * DIGITS;

  conv_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic              sign_q, sign_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              neg_q, neg_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              err_q, err_d;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     acc_shift;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (acc_q[4*gi +: 4]),
        .dout (adj[4*gi +: 4])
      );
    end
  endgenerate

  // The magnitude MSB shifts into the bottom of the corrected accumulator.
  assign acc_shift = {adj[BW-2:0], mag_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          busy_d = 1'b1;
          if (err_in) begin
            state_d = DONE;
            valid_d = 1'b1;
            neg_d   = 1'b0;
            bcd_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = CONV;
            sign_d  = d_in[WIDTH-1];
            mag_d   = d_in[WIDTH-1] ? ((~d_in) + {{(WIDTH-1){1'b0}}, 1'b1}) : d_in;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
      end
      CONV: begin
        acc_d = acc_shift;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
          valid_d = 1'b1;
          bcd_d   = acc_shift;
          neg_d   = sign_q;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  assign busy      = busy_q;
  assign valid_out = valid_q;
  assign neg       = neg_q;
  assign bcd       = bcd_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed checks for bin2bcd_conv. Latency n counts edges after the sampling
// edge T; valid_out first seen right after edge T+n is high in cycle T+n+1.
module tb_bin2bcd_conv;
  import calc_pkg::*;

  localparam int W  = CALC_WIDTH;
  localparam int BW = 4 * CALC_DIGITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [W-1:0]  d_in;
  logic          err_in;
  logic          busy;
  logic          valid_out;
  logic          neg;
  logic [BW-1:0] bcd;
  logic          err_out;

  int tests = 0;
  int fails = 0;

  int            pulses;
  int            first;
  logic [BW-1:0] cap_bcd;
  logic          cap_neg;
  logic          cap_err;
  logic          busy_mid;
  logic          busy_after;
  logic          rs_busy, rs_valid, rs_neg, rs_err;
  logic [BW-1:0] rs_bcd;

  bin2bcd_conv dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .d_in      (d_in),
    .err_in    (err_in),
    .busy      (busy),
    .valid_out (valid_out),
    .neg       (neg),
    .bcd       (bcd),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operand, then watch 64 edges. Optional extra valid_in at
  // inj_at, at the edge DONE leaves (inj_done), and a reset at rst_at.
  task automatic op(input logic [W-1:0] d, input logic e, input int inj_at,
                    input logic inj_done, input int rst_at);
    @(negedge clk);
    valid_in = 1'b1;
    d_in     = d;
    err_in   = e;
    @(posedge clk);
    pulses     = 0;
    first      = -1;
    busy_mid   = 1'b0;
    busy_after = 1'b1;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (valid_out) begin
        if (first < 0) begin
          first   = n;
          cap_bcd = bcd;
          cap_neg = neg;
          cap_err = err_out;
        end
        pulses++;
      end
      if (n == 1) busy_mid = busy;
      if (first >= 0 && n == first + 1) busy_after = busy;
      if (rst_at >= 0 && n == rst_at + 1) begin
        rs_busy  = busy;
        rs_valid = valid_out;
        rs_neg   = neg;
        rs_err   = err_out;
        rs_bcd   = bcd;
      end
      valid_in = (n == inj_at) || (inj_done && first >= 0 && n == first);
      d_in     = W'(999);
      err_in   = 1'b0;
      rst      = (n == rst_at);
      @(posedge clk);
    end
    valid_in = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    d_in     = '0;
    err_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_valid_out", 64'(valid_out), 64'd0);
    check("reset_neg",       64'(neg),       64'd0);
    check("reset_err_out",   64'(err_out),   64'd0);
    check("reset_bcd",       64'(bcd),       64'd0);
    @(negedge clk);
    rst = 1'b0;

    op(W'(100), 1'b0, -1, 1'b0, -1);
    $display("[TB] d=100 lat=%0d bcd=%h neg=%0d err=%0d", first, cap_bcd, cap_neg, cap_err);
    check("d100_latency", 64'(first), 64'd28);
    check("d100_pulses",  64'(pulses), 64'd1);
    check("d100_bcd",     64'(cap_bcd), 64'h000000100);
    check("d100_neg",     64'(cap_neg), 64'd0);
    check("d100_err",     64'(cap_err), 64'd0);
    check("d100_busy_mid", 64'(busy_mid), 64'd1);
    check("d100_busy_after", 64'(busy_after), 64'd0);
    check("d100_hold_bcd", 64'(bcd), 64'h000000100);

    op(28'hFFFFFFF, 1'b0, -1, 1'b0, -1);
    $display("[TB] d=-1 lat=%0d bcd=%h neg=%0d", first, cap_bcd, cap_neg);
    check("m1_bcd", 64'(cap_bcd), 64'h000000001);
    check("m1_neg", 64'(cap_neg), 64'd1);

    op(28'h7FFFFFF, 1'b0, -1, 1'b0, -1);
    $display("[TB] d=max lat=%0d bcd=%h neg=%0d", first, cap_bcd, cap_neg);
    check("max_bcd", 64'(cap_bcd), 64'h134217727);
    check("max_neg", 64'(cap_neg), 64'd0);

    op(28'h8000000, 1'b0, -1, 1'b0, -1);
    $display("[TB] d=min lat=%0d bcd=%h neg=%0d", first, cap_bcd, cap_neg);
    check("min_bcd", 64'(cap_bcd), 64'h134217728);
    check("min_neg", 64'(cap_neg), 64'd1);
    check("min_hold_neg", 64'(neg), 64'd1);

    op(W'(12345), 1'b1, -1, 1'b0, -1);
    $display("[TB] err lat=%0d bcd=%h neg=%0d err=%0d", first, cap_bcd, cap_neg, cap_err);
    check("err_latency", 64'(first), 64'd0);
    check("err_pulses",  64'(pulses), 64'd1);
    check("err_err_out", 64'(cap_err), 64'd1);
    check("err_bcd",     64'(cap_bcd), 64'd0);
    check("err_neg",     64'(cap_neg), 64'd0);
    check("err_busy_after", 64'(busy_after), 64'd0);

    op(W'(0), 1'b0, -1, 1'b0, -1);
    $display("[TB] d=0 lat=%0d bcd=%h err=%0d", first, cap_bcd, cap_err);
    check("zero_bcd", 64'(cap_bcd), 64'd0);
    check("zero_err_cleared", 64'(cap_err), 64'd0);

    op(W'(12345678), 1'b0, 9, 1'b1, -1);
    $display("[TB] busy-ignore lat=%0d pulses=%0d bcd=%h", first, pulses, cap_bcd);
    check("ign_latency", 64'(first), 64'd28);
    check("ign_pulses",  64'(pulses), 64'd1);
    check("ign_bcd",     64'(cap_bcd), 64'h012345678);
    check("ign_busy_after", 64'(busy_after), 64'd0);
    check("ign_hold_bcd", 64'(bcd), 64'h012345678);

    op(W'(555), 1'b0, -1, 1'b0, 14);
    $display("[TB] mid-reset pulses=%0d busy=%0d bcd=%h", pulses, rs_busy, rs_bcd);
    check("rst_pulses", 64'(pulses), 64'd0);
    check("rst_busy",   64'(rs_busy), 64'd0);
    check("rst_valid",  64'(rs_valid), 64'd0);
    check("rst_neg",    64'(rs_neg), 64'd0);
    check("rst_err",    64'(rs_err), 64'd0);
    check("rst_bcd",    64'(rs_bcd), 64'd0);

    op(W'(42), 1'b0, -1, 1'b0, -1);
    $display("[TB] d=42 lat=%0d bcd=%h neg=%0d", first, cap_bcd, cap_neg);
    check("d42_latency", 64'(first), 64'd28);
    check("d42_bcd", 64'(cap_bcd), 64'h000000042);
    check("d42_neg", 64'(cap_neg), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_conv.md
BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 Parameter: WIDTH, 28, operand width in bits (two's complement, bit WIDTH-1 is sign).
REQ-002 Parameter: DIGITS, 9, number of BCD output digits; 9 covers the magnitude 2^27.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: valid_in  input  1  one-cycle strobe; d_in and err_in are valid this cycle (driven by the divider's valid_out).
REQ-006 Port: d_in  input  WIDTH  signed quotient to display.
REQ-007 Port: err_in  input  1  divide-by-zero flag accompanying valid_in.
REQ-008 Port: busy  output  1  high while a conversion is in progress.
REQ-009 Port: valid_out  output  1  one-cycle strobe; neg, bcd and err_out are updated this cycle.
REQ-010 Port: neg  output  1  result sign; 1 = negative.
REQ-011 Port: bcd  output  4*DIGITS  magnitude as packed BCD, most significant digit in the top nibble.
REQ-012 Port: err_out  output  1  latched error flag for the display.

Function
REQ-013 States: IDLE, CONV, DONE; the block leaves reset in IDLE.
REQ-014 IDLE, valid_in=1, err_in=0: capture neg=d_in[WIDTH-1].
REQ-015 Same capture: magnitude = d_in if d_in[WIDTH-1]=0, else (~d_in)+1, computed as an unsigned WIDTH-bit value.
REQ-016 Same capture: clear the BCD accumulator, load bit counter = WIDTH-1, go to CONV.
REQ-017 -2^(WIDTH-1) (0x8000000) has a WIDTH-bit unsigned magnitude 2^(WIDTH-1) with neg=1; no overflow handling is needed.
REQ-018 CONV, per cycle: add 3 to every accumulator digit that is >=5, then shift {accumulator, magnitude} left 1 bit.
REQ-019 CONV: exactly WIDTH cycles; decrement the counter each cycle; leave for DONE when the counter is 0.
REQ-020 DONE: register bcd, neg and err_out=0, pulse valid_out=1 for one cycle, return to IDLE.
REQ-021 Latency: valid_in sampled at edge T gives valid_out high during cycle T+WIDTH+1 (T+29 at default).
REQ-022 busy=1 in CONV and DONE, 0 in IDLE.
REQ-023 IDLE, valid_in=1, err_in=1: skip conversion, go to DONE next cycle with bcd=0, neg=0, err_out=1; valid_out in cycle T+1.
REQ-024 valid_in while busy=1 is ignored, with no effect on the current conversion; no queueing.
REQ-025 valid_in in the same cycle that DONE returns to IDLE is ignored; acceptance requires state IDLE at the sampling edge.
REQ-026 bcd, neg and err_out hold their last values between valid_out pulses.
REQ-027 Every output digit is always in 0..9.

Reset
REQ-028 rst=1 at an edge: state=IDLE, busy=0, valid_out=0, neg=0, err_out=0, bcd=0, accumulator and counter=0.
REQ-029 Reset during CONV aborts the conversion; no valid_out is issued for the aborted operand.
REQ-030 rst has priority over valid_in in the same cycle.

Structure
REQ-031 The shared package calc_pkg holds WIDTH, DIGITS and the state enumeration, so they are shared with the divider and display stages.
REQ-032 One combinational sub-module, bcd_add3 (4-bit in, 4-bit out, adds 3 when >=5), is instantiated DIGITS times.
REQ-033 No other sub-modules; one clocked process and one next-state process.

Verification
REQ-034 d_in=100, valid_in -> valid_out at T+29: bcd=0x000000100, neg=0, err_out=0.
REQ-035 d_in=0xFFFFFFF (-1) -> bcd=0x000000001, neg=1; d_in=0x7FFFFFF -> bcd=0x134217727, neg=0.
REQ-036 d_in=0x8000000 (-134217728) -> bcd=0x134217728, neg=1.
REQ-037 valid_in with err_in=1 -> valid_out at T+1: err_out=1, bcd=0, neg=0, busy back to 0 at T+2.
REQ-038 Second valid_in at T+10 during conversion -> ignored; exactly one valid_out, at T+29, for the first operand.
REQ-039 rst at T+15 mid-conversion -> all outputs 0 at T+16, no valid_out; a fresh d_in=42 afterwards -> bcd=0x000000042.
